// File: rtl/stack_pop_reader.sv
// Pop engine for the downward-growing CPU stack: reads mem[esp] and returns the word, then issues esp+1.
// Optional STACK_POP_PEEK_EN adds a peek input: the top word is read but esp is left unchanged.
module stack_pop_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pop_req,
  input  logic              push_busy,
  output logic              pop_ready,
  input  logic [31:0]       esp_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              pop_valid,
  input  logic              pop_taken,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_err,
  output logic              esp_we,
  output logic [31:0]       esp_out
`ifdef STACK_POP_PEEK_EN
  ,
  input  logic              peek
`endif
);

  // state | meaning
  // IDLE  | ready for a request unless the push path is busy
  // ISSUE | read strobe to memory at the latched esp
  // WAIT  | counting down the memory read latency
  // DONE  | result held valid until taken
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = 2;

  state_t             state, state_nxt;
  logic [31:0]        esp_q;
  logic [CNT_W-1:0]   cnt;
  logic               peek_in;
  logic               peek_q;
  logic               accept;
  logic               underflow;

`ifdef STACK_POP_PEEK_EN
  assign peek_in = peek;
`else
  assign peek_in = 1'b0;
`endif

  assign underflow = (esp_in >= 32'(DEPTH));
  assign accept    = pop_req && pop_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_ready = 1'b0;
    mem_rd_en = 1'b0;
    pop_valid = 1'b0;
    case (state)
      S_IDLE: begin
        pop_ready = !push_busy;
        if (pop_req && !push_busy) state_nxt = underflow ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        pop_valid = 1'b1;
        if (pop_taken) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // esp_we is a single-cycle pulse raised on the WAIT->DONE edge, so underflow never produces one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      esp_q    <= '0;
      peek_q   <= 1'b0;
      cnt      <= '0;
      mem_addr <= '0;
      pop_data <= '0;
      pop_err  <= 1'b0;
      esp_we   <= 1'b0;
      esp_out  <= '0;
    end else begin
      esp_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            esp_q   <= esp_in;
            peek_q  <= peek_in;
            pop_err <= underflow;
            if (underflow) pop_data <= '0;
            else           mem_addr <= esp_in[ADDR_W-1:0];
          end
        end
        S_ISSUE: cnt <= CNT_W'(RD_LAT - 1);
        S_WAIT: begin
          if (cnt == '0) begin
            pop_data <= mem_rd_data;
            esp_we   <= !peek_q;
            esp_out  <= esp_q + 32'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (pop_taken) pop_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_pop_reader.sv
// Bench for stack_pop_reader: two instances (read latency 1 and 3) share stimulus; a scoreboard
// queue per instance holds expected results that a negedge monitor pops and compares.
module tb_stack_pop_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pop_req = 1'b0;
  logic        push_busy = 1'b0;
  logic        pop_taken = 1'b1;
  logic [31:0] esp_in = '0;
`ifdef STACK_POP_PEEK_EN
  logic        peek = 1'b0;
`endif

  logic        pop_ready   [2];
  logic        mem_rd_en   [2];
  logic [4:0]  mem_addr    [2];
  logic [31:0] mem_rd_data [2];
  logic        pop_valid   [2];
  logic [31:0] pop_data    [2];
  logic        pop_err     [2];
  logic        esp_we      [2];
  logic [31:0] esp_out     [2];

  logic [31:0] mem [32];
  int cyc = 0;
  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  stack_pop_reader #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(1)) u0 (
    .clock(clock), .reset(reset), .pop_req(pop_req), .push_busy(push_busy),
    .pop_ready(pop_ready[0]), .esp_in(esp_in), .mem_rd_en(mem_rd_en[0]),
    .mem_addr(mem_addr[0]), .mem_rd_data(mem_rd_data[0]), .pop_valid(pop_valid[0]),
    .pop_taken(pop_taken), .pop_data(pop_data[0]), .pop_err(pop_err[0]),
`ifdef STACK_POP_PEEK_EN
    .peek(peek),
`endif
    .esp_we(esp_we[0]), .esp_out(esp_out[0]));

  stack_pop_reader #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(3)) u1 (
    .clock(clock), .reset(reset), .pop_req(pop_req), .push_busy(push_busy),
    .pop_ready(pop_ready[1]), .esp_in(esp_in), .mem_rd_en(mem_rd_en[1]),
    .mem_addr(mem_addr[1]), .mem_rd_data(mem_rd_data[1]), .pop_valid(pop_valid[1]),
    .pop_taken(pop_taken), .pop_data(pop_data[1]), .pop_err(pop_err[1]),
`ifdef STACK_POP_PEEK_EN
    .peek(peek),
`endif
    .esp_we(esp_we[1]), .esp_out(esp_out[1]));

  // Memory models: data is only meaningful in the exact cycle the latency promises
  logic       p0_v = 1'b0;
  logic [4:0] p0_a = '0;
  logic       p1_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0] p1_a [3] = '{5'd0, 5'd0, 5'd0};
  always @(posedge clock) begin
    p0_v <= mem_rd_en[0];
    p0_a <= mem_addr[0];
    p1_v[0] <= mem_rd_en[1];
    p1_a[0] <= mem_addr[1];
    p1_v[1] <= p1_v[0];
    p1_a[1] <= p1_a[0];
    p1_v[2] <= p1_v[1];
    p1_a[2] <= p1_a[1];
  end
  assign mem_rd_data[0] = p0_v    ? mem[p0_a]    : 32'hBAD0BAD0;
  assign mem_rd_data[1] = p1_v[2] ? mem[p1_a[2]] : 32'hBAD0BAD0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        we;
    logic [31:0] eo;
    logic [4:0]  addr;
    int          vcyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Monitor
  logic prev_v [2] = '{1'b0, 1'b0};
  exp_t cur [2];
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          lat = (i == 0) ? 1 : 3;
          if (mem_rd_en[i]) begin
            if (qsize(i) == 0) check($sformatf("rd_unexpected[%0d]", i), mem_rd_en[i], 0);
            else begin
              e = qfront(i);
              if (e.err) check($sformatf("rd_on_underflow[%0d]", i), mem_rd_en[i], 0);
              else begin
                check($sformatf("rd_addr[%0d]", i), mem_addr[i], e.addr);
                check($sformatf("rd_cycle[%0d]", i), cyc, e.vcyc - lat - 1);
              end
            end
          end
          if (pop_valid[i] && !prev_v[i]) begin
            if (qsize(i) == 0) check($sformatf("valid_unexpected[%0d]", i), pop_valid[i], 0);
            else begin
              e = qpop(i);
              cur[i] = e;
              check($sformatf("pop_data[%0d]", i), pop_data[i], e.data);
              check($sformatf("pop_err[%0d]", i), pop_err[i], e.err);
              check($sformatf("valid_cycle[%0d]", i), cyc, e.vcyc);
              check($sformatf("esp_we[%0d]", i), esp_we[i], e.we);
              if (e.we) check($sformatf("esp_out[%0d]", i), esp_out[i], e.eo);
            end
          end else begin
            if (esp_we[i]) check($sformatf("esp_we_extra[%0d]", i), esp_we[i], 0);
            if (pop_valid[i]) begin
              check($sformatf("hold_data[%0d]", i), pop_data[i], cur[i].data);
              check($sformatf("hold_err[%0d]", i), pop_err[i], cur[i].err);
            end
          end
          prev_v[i] = pop_valid[i];
        end
      end
    end
  end

  task automatic issue(input logic [31:0] esp, input logic pk, input int busy);
    exp_t e;
    int ec;
    @(negedge clock);
    esp_in = esp;
`ifdef STACK_POP_PEEK_EN
    peek = pk;
`endif
    pop_req = 1'b1;
    push_busy = (busy > 0);
    for (int k = 0; k < busy; k++) begin
      #1;
      check("busy_ready[0]", pop_ready[0], 0);
      check("busy_ready[1]", pop_ready[1], 0);
      @(negedge clock);
    end
    push_busy = 1'b0;
    @(posedge clock);
    #1;
    ec = cyc;
    pop_req = 1'b0;
    e.err  = (esp >= 32);
    e.data = e.err ? 32'h0 : mem[esp[4:0]];
    e.we   = !e.err && !pk;
    e.eo   = esp + 32'd1;
    e.addr = esp[4:0];
    e.vcyc = e.err ? ec : ec + 2;
    q0.push_back(e);
    e.vcyc = e.err ? ec : ec + 4;
    q1.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && !pop_valid[0] && !pop_valid[1]) break;
    end
    check("drain_pending", q0.size() + q1.size() + int'(pop_valid[0]) + int'(pop_valid[1]), 0);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_valid[%0d]", tag, i), pop_valid[i], 0);
      check($sformatf("%s_rd_en[%0d]", tag, i), mem_rd_en[i], 0);
      check($sformatf("%s_esp_we[%0d]", tag, i), esp_we[i], 0);
      check($sformatf("%s_err[%0d]", tag, i), pop_err[i], 0);
      check($sformatf("%s_data[%0d]", tag, i), pop_data[i], 0);
      check($sformatf("%s_esp_out[%0d]", tag, i), esp_out[i], 0);
      check($sformatf("%s_addr[%0d]", tag, i), mem_addr[i], 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[30] = 32'hDEADBEEF;
    mem[31] = 32'h12345678;
    mem[5]  = 32'hA5A5A5A5;
    mem[0]  = 32'h00C0FFEE;
    mem[10] = 32'h00000055;

    #3 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    #1;
    check("idle_ready[0]", pop_ready[0], 1);
    check("idle_ready[1]", pop_ready[1], 1);

    // normal pop, taken immediately
    issue(32'd30, 1'b0, 0);
    drain();

    // underflow: empty and far out of range
    issue(32'd32, 1'b0, 0);
    drain();
    issue(32'hFFFF_FFFF, 1'b0, 0);
    drain();

    // last word, consumer stalls 4 cycles; a request during DONE must be dropped
    pop_taken = 1'b0;
    issue(32'd31, 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      #1;
      if (pop_valid[1]) break;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      check("stall_ready[0]", pop_ready[0], 0);
      check("stall_ready[1]", pop_ready[1], 0);
      check("stall_valid[0]", pop_valid[0], 1);
      check("stall_valid[1]", pop_valid[1], 1);
      if (k == 1) begin
        esp_in = 32'd3;
        pop_req = 1'b1;
      end
      if (k == 2) pop_req = 1'b0;
    end
    pop_taken = 1'b1;
    @(negedge clock);
    #1;
    check("after_taken_ready[0]", pop_ready[0], 1);
    check("after_taken_ready[1]", pop_ready[1], 1);
    check("after_taken_valid[0]", pop_valid[0], 0);
    check("after_taken_valid[1]", pop_valid[1], 0);
    drain();

    // push path holds off the pop for 3 cycles
    issue(32'd5, 1'b0, 3);
    drain();

    // asynchronous reset while both instances are in WAIT
    issue(32'd20, 1'b0, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_zero("abort");
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    issue(32'd0, 1'b0, 0);
    drain();

`ifdef STACK_POP_PEEK_EN
    issue(32'd10, 1'b1, 0);
    drain();
    issue(32'd40, 1'b1, 0);
    drain();
    issue(32'd10, 1'b0, 0);
    drain();
`endif

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stack_pop_reader.md
Name: stack_pop_reader

Overview:
- Read-side (pop) engine for the 32-word CPU stack memory; complements the push/write path that stores write_data at mem[esp].
- Accepts a pop request from the control sequencer, reads mem[esp] through a synchronous read port, returns the word with a valid/taken handshake, and issues the esp update.
- Stack grows downward: push pre-decrements esp and writes; pop reads mem[esp] then esp+1. Empty when esp == DEPTH.

Parameters:
- DATA_W, 32, stack word width
- ADDR_W, 5, memory index width
- DEPTH, 32, number of words; esp == DEPTH means empty
- RD_LAT, 1, memory read latency in cycles (1..3) from mem_rd_en cycle to mem_rd_data valid cycle

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- pop_req  in  1  pop request; sampled in IDLE only
- push_busy  in  1  write path active; blocks acceptance
- pop_ready  out  1  high in IDLE with push_busy=0
- esp_in  in  32  current stack pointer (word index)
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read index
- mem_rd_data  in  DATA_W  memory read data
- pop_valid  out  1  result valid; held until pop_taken
- pop_taken  in  1  consumer accepts result
- pop_data  out  DATA_W  popped word
- pop_err  out  1  underflow flag, qualified by pop_valid
- esp_we  out  1  one-cycle esp write strobe
- esp_out  out  32  new esp value, qualified by esp_we

Behaviour:
- Reset (asynchronous, active-high): state IDLE; pop_valid, pop_err, esp_we, mem_rd_en = 0; pop_data, esp_out, mem_addr = 0; RD_LAT counter = 0. Reset mid-operation aborts the pop; no esp_we is ever issued for an aborted pop.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: accept on the edge where pop_req=1 and pop_ready=1; latch esp_in.
  - If latched esp >= DEPTH (underflow): go to DONE with pop_err=1, pop_data=0, no memory read, no esp_we.
  - Otherwise go to ISSUE.
- ISSUE (one cycle): mem_rd_en=1, mem_addr=esp[ADDR_W-1:0]; load counter = RD_LAT-1; go to WAIT.
- WAIT: decrement counter each cycle. When the count reaches 0, mem_rd_data is valid that cycle; capture it into pop_data at the edge and go to DONE.
- DONE: pop_valid=1, and pop_data stable while pop_valid.
  - First DONE cycle only: esp_we=1, esp_out=latched esp+1 (never for an error).
  - On pop_taken=1, clear pop_valid/pop_err at the edge and go to IDLE.
  - pop_taken in the first DONE cycle is legal, giving a 1-cycle valid.
- Latency (RD_LAT=1): req sampled at edge 0; mem_rd_en in cycle 1; data in cycle 2; pop_valid and esp_we in cycle 3. In general req-to-valid = RD_LAT+2 cycles. Underflow: pop_valid in cycle 1.
- pop_ready=0 outside IDLE; pop_req while not ready is ignored (not queued).
- push_busy=1 and pop_req=1 together: push wins, pop not accepted until push_busy=0.
- esp arithmetic is 32-bit unsigned. esp=DEPTH-1 pops the last word and yields esp_out=DEPTH (empty); no wrap.
- pop_taken outside DONE: ignored.

Optional Feature:
- Macro STACK_POP_PEEK_EN.
- Defined: adds input port peek (1 bit), latched with pop_req at acceptance. A peek read is identical to a pop except esp_we stays 0 (top-of-stack read without removal). Underflow on peek still sets pop_err.
- Undefined: no peek port; every accepted request is a pop.

Test Plan:
- Preload mem[30]=0xDEADBEEF, esp_in=30, RD_LAT=1, pop_req pulse, pop_taken held 1 -> mem_rd_en cycle 1 with mem_addr=30; pop_valid cycle 3 with pop_data=0xDEADBEEF, pop_err=0; esp_we one cycle with esp_out=31.
- esp_in=32, pop_req -> no mem_rd_en; pop_valid cycle 1 with pop_err=1, pop_data=0, esp_we never asserted.
- esp_in=31 with mem[31]=0x12345678, pop_taken delayed 4 cycles -> pop_valid and pop_data held 4+ cycles, esp_we exactly one pulse (esp_out=32), pop_ready=0 until the cycle after pop_taken.
- RD_LAT=3, esp_in=5, mem[5]=0xA5A5A5A5 -> pop_valid at cycle 5, data 0xA5A5A5A5; push_busy=1 with pop_req for 3 cycles -> not accepted until push_busy drops.
- Reset asserted asynchronously in WAIT -> all outputs 0 immediately, no esp_we; after release, a new pop at esp=0 completes normally.
- With STACK_POP_PEEK_EN, peek=1, esp_in=10, mem[10]=0x55 -> pop_valid with pop_data=0x55, esp_we stays 0.
